// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Booth recoding of {Q[0], q_1}; the remaining codes (00, 11) leave A unchanged.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/subtract M into A, then
// arithmetic-shift {A,Q,q_1} right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
    // A's MSB is replicated so the partial product keeps its sign.
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/mult_booth_ctrl.sv
// Sequential signed multiplier: one Booth step per clock, WIDTH steps per
// product, registered result with a one-cycle done pulse.
module mult_booth_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q1_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;
  logic [2*WIDTH-1:0] result_reg;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q1_next;
  logic             last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_reg),
    .q        (q_reg),
    .q_1      (q1_reg),
    .m        (m_reg),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q1_next)
  );

  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge; start is ignored in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      q_reg      <= '0;
      q1_reg     <= 1'b0;
      m_reg      <= '0;
      count      <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg  <= '0;
            q_reg  <= operand_b;
            q1_reg <= 1'b0;
            m_reg  <= operand_a;
            count  <= '0;
          end
        end
        CALC: begin
          a_reg  <= a_next;
          q_reg  <= q_next;
          q1_reg <= q1_next;
          count  <= count + 1'b1;
          if (last_step) result_reg <= {a_next[WIDTH-1:0], q_next};
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl (WIDTH=8) with hand-computed products.
module tb_mult_booth_ctrl;

  localparam int W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic [2*W-1:0]   result;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  mult_booth_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands in cycle 0; returns at the sample point of cycle 1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1; returns with cyc = cycle index where done is seen.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 30) begin
      tick();
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
    int cyc;
    start_op(a, b);
    wait_done(tag, cyc);
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    int cyc;
    int n_done;
    int first_done;
    int bad;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b1;
    operand_a = 8'd3;
    operand_b = 8'd3;
    tick();
    tick();
    // reset overrides start
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // basic 7 * -3 with busy window check
    start_op(8'd7, 8'hFD);
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      operand_a = 8'd99;
      operand_b = 8'd99;
      if (c < 8) tick();
    end
    check("basic_busy_window", bad, 0);
    tick();
    check("basic_done_c9", done, 1);
    check("basic_busy_c9", busy, 0);
    check("basic_result", result, 16'hFFEB);
    tick();
    check("basic_done_c10", done, 0);
    check("basic_hold", result, 16'hFFEB);
    tick();

    // corner products
    run_mult("neg128_sq", 8'h80, 8'h80, 16'h4000);
    tick();
    run_mult("p127_n128", 8'h7F, 8'h80, 16'hC080);
    tick();
    run_mult("zero_n77", 8'h00, 8'hB3, 16'h0000);
    tick();
    run_mult("n1_n1", 8'hFF, 8'hFF, 16'h0001);
    tick();

    // start while busy is ignored
    start_op(8'd7, 8'hFD);
    tick(); tick(); tick();            // cycle 4
    start     = 1'b1;
    operand_a = 8'd5;
    operand_b = 8'd5;
    tick();                            // cycle 5
    start      = 1'b0;
    n_done     = 0;
    first_done = 0;
    for (int c = 5; c <= 14; c++) begin
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c < 14) tick();
    end
    check("busy_start_ndone", n_done, 1);
    check("busy_start_cycle", first_done, 9);
    check("busy_start_result", result, 16'hFFEB);
    tick();

    // reset mid-operation
    start_op(8'd9, 8'd9);
    tick(); tick(); tick();            // cycle 4
    tick();                            // cycle 5
    rst = 1'b1;
    tick();                            // cycle 6
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_done", done, 0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_mult("after_rst_12x12", 8'd12, 8'd12, 16'd144);
    tick();

    // back-to-back: start held in DONE
    start_op(8'd7, 8'hFD);
    wait_done("b2b_first", cyc);
    check("b2b_first_latency", cyc, 9);
    check("b2b_first_result", result, 16'hFFEB);
    start_op(8'd5, 8'd5);
    check("b2b_no_idle_busy", busy, 1);
    bad = 0;
    cyc = 1;
    while (!done && cyc < 30) begin
      if (result !== 16'hFFEB) bad++;
      tick();
      cyc++;
    end
    check("b2b_hold_prev", bad, 0);
    check("b2b_second_latency", cyc, 9);
    check("b2b_second_result", result, 16'd25);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_booth_ctrl.md
MULT_BOOTH_CTRL -- requirements
Module: mult_booth_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (two's complement).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to multiply the operands presented in the same cycle (driven by the digit-capture block's valid).
REQ-005 The block SHALL have ports operand_a and operand_b, input, WIDTH bits each: signed multiplicand and multiplier.
REQ-006 The block SHALL have port result, output, 2*WIDTH bits: signed product, registered.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the cycle in which a new result is first valid.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-010 In IDLE or DONE, start=1 SHALL load M=operand_a, A=0 (WIDTH+1 bits), Q=operand_b, q_1=0 and count=0, and SHALL enter CALC.
REQ-011 In CALC, each edge SHALL perform one radix-2 Booth step on {Q[0],q_1}: 01 adds M sign-extended to A; 10 subtracts it; 00 and 11 leave A unchanged.
REQ-012 Each step SHALL then arithmetic-shift {A,Q,q_1} right by one, replicating A's MSB.
REQ-013 A SHALL be WIDTH+1 bits so that -2^(WIDTH-1) * -2^(WIDTH-1) does not overflow.
REQ-014 count SHALL increment on each CALC edge.
REQ-015 On the WIDTH-th step, the FSM SHALL move to DONE and register result={A[WIDTH-1:0],Q}, computed from the post-shift values.
REQ-016 DONE SHALL last exactly one cycle, returning to IDLE unless start=1 (REQ-010 applies).
REQ-017 done SHALL be 1 only in DONE.
REQ-018 busy SHALL be 1 only in CALC.
REQ-019 Latency: with start high in cycle 0, done SHALL be high in cycle WIDTH+1 (cycle 9 for WIDTH=8).
REQ-020 start SHALL be ignored while in CALC; the operands SHALL be sampled only on the accepting edge.
REQ-021 result SHALL hold its value until the next DONE; operand changes after acceptance SHALL have no effect.
REQ-022 Back-to-back: start in DONE SHALL begin a new operation with no IDLE cycle, while result keeps the previous product until the new DONE.

Reset
REQ-023 rst=1 on an edge SHALL force state=IDLE, result=0, busy=0, done=0, A=Q=M=0, q_1=0, count=0, overriding start.
REQ-024 Reset during CALC SHALL abandon the operation with no done pulse.
REQ-025 After rst is released, the first start SHALL behave as in REQ-010.

Structure
REQ-026 Package mult_pkg SHALL hold the state enum (IDLE, CALC, DONE), WIDTH's default constant and the Booth code constants.
REQ-027 The combinational add/sub-and-shift step SHALL be a sub-module named booth_step (inputs A, Q, q_1, M; outputs next A, Q, q_1).
REQ-028 The block SHALL have no latches; every combinational output SHALL be assigned on all paths.

Verification
REQ-029 Basic product: operand_a=7, operand_b=-3, start pulse -> done in cycle 9, result=16'hFFEB (-21), busy high cycles 1-8.
REQ-030 Corner products:
- -128 * -128 -> result=16'h4000.
- 127 * -128 -> result=16'hC080.
- 0 * -77 -> result=0.
REQ-031 Start while busy: start re-pulsed in cycle 4 with new operands -> ignored; a single done in cycle 9 with the original product.
REQ-032 Reset mid-operation: rst in cycle 5 -> busy=0, result=0 next cycle, no done pulse; a fresh start 12*12 -> result=144.
REQ-033 Back-to-back: start held in the DONE cycle with 5*5 after 7*-3 -> result stays 16'hFFEB until the second done, nine cycles later, when it becomes 25.
